// File: rtl/arithmetic_calculator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and widths for the arithmetic calculator.
//               Holds the opcode and FSM state enums and the fixed operand and
//               result widths.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int c_OPERAND_W = 4;
    localparam int c_RESULT_W  = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_GCD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/arithmetic_calculator_if.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_calculator_if
// Description : Request/result bundle of the arithmetic calculator.
//               master : drives start, opcode, operand_A, operand_B;
//                        observes result, done, error.
//               slave  : the calculator side (mirror of master).
// Revision    : 1.0 - initial release
// ============================================================================
interface arithmetic_calculator_if;
    import calc_pkg::*;

    logic                   start;
    logic [2:0]             opcode;
    logic [c_OPERAND_W-1:0] operand_A;
    logic [c_OPERAND_W-1:0] operand_B;
    logic [c_RESULT_W-1:0]  result;
    logic                   done;
    logic                   error;

    modport master (
        output start, opcode, operand_A, operand_B,
        input  result, done, error
    );

    modport slave (
        input  start, opcode, operand_A, operand_B,
        output result, done, error
    );

endinterface
`default_nettype wire

// File: rtl/arithmetic_calculator_div.sv
`default_nettype none
// ============================================================================
// Module      : calc_div_unit
// Description : Iterative 4-bit unsigned restoring divider, one quotient bit
//               per cycle (4 cycles). A zero divisor is flagged for one busy
//               cycle and no iterations are run.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_start           - load dividend/divisor and begin
//               i_dividend/i_divisor - operands
//               o_busy            - division in progress
//               o_done            - high during the final step; quotient and
//                                   remainder outputs are valid in that cycle
//               o_div_by_zero     - loaded divisor is zero
//               o_quotient/o_remainder - values after the current step
// Revision    : 1.0 - initial release
// ============================================================================
module calc_div_unit
    import calc_pkg::*;
(
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    i_start,
    input  wire [c_OPERAND_W-1:0]  i_dividend,
    input  wire [c_OPERAND_W-1:0]  i_divisor,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_div_by_zero,
    output logic [c_OPERAND_W-1:0] o_quotient,
    output logic [c_OPERAND_W-1:0] o_remainder
);

    logic                   r_busy;
    logic [2:0]             r_count;
    logic [c_OPERAND_W-1:0] r_rem;
    logic [c_OPERAND_W-1:0] r_quo;
    logic [c_OPERAND_W-1:0] r_divisor;

    logic [c_OPERAND_W:0]   w_trial;
    logic                   w_fits;
    logic [c_OPERAND_W-1:0] w_rem_sub;
    logic [c_OPERAND_W-1:0] w_rem_next;
    logic [c_OPERAND_W-1:0] w_quo_next;
    logic                   w_dbz;

    // Shift the next dividend bit into the partial remainder; the trial is
    // 5 bits wide so that a carry into bit 4 still compares correctly.
    assign w_trial    = {r_rem, r_quo[c_OPERAND_W-1]};
    assign w_fits     = (w_trial >= {1'b0, r_divisor});
    // When the trial fits, the difference is below the divisor, so 4 bits suffice.
    assign w_rem_sub  = w_trial[c_OPERAND_W-1:0] - r_divisor;
    assign w_rem_next = w_fits ? w_rem_sub : w_trial[c_OPERAND_W-1:0];
    assign w_quo_next = {r_quo[c_OPERAND_W-2:0], w_fits};
    assign w_dbz      = (r_divisor == '0);

    assign o_busy        = r_busy;
    assign o_div_by_zero = w_dbz;
    assign o_done        = r_busy && !w_dbz && (r_count == 3'd1);
    assign o_quotient    = w_quo_next;
    assign o_remainder   = w_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_count   <= 3'd0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_count   <= 3'd4;
            r_rem     <= '0;
            r_quo     <= i_dividend;
            r_divisor <= i_divisor;
        end else if (r_busy) begin
            if (w_dbz) begin
                r_busy <= 1'b0;
            end else begin
                r_rem   <= w_rem_next;
                r_quo   <= w_quo_next;
                r_count <= r_count - 3'd1;
                if (r_count == 3'd1) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arithmetic_calculator.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_calculator
// Description : 4-bit operand / 8-bit result calculator with IDLE/BUSY/DONE
//               FSM. Single-cycle ADD/SUB/MUL/AND/OR/XOR, 4-cycle restoring
//               DIV (calc_div_unit), iterative subtract-and-swap GCD.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - arithmetic_calculator_if.slave
//                          (start, opcode, operand_A, operand_B in;
//                           result, done, error out)
// Config      : CALC_GCD_EN - when defined, GCD (opcode 100) is built;
//               otherwise opcode 100 reports error like any undefined opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module arithmetic_calculator
    import calc_pkg::*;
(
    input  wire                    clk,
    input  wire                    rst,
    arithmetic_calculator_if.slave bus
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   w_accept;

    opcode_e                r_op;
    logic [c_OPERAND_W-1:0] r_a;
    logic [c_OPERAND_W-1:0] r_b;

    logic [c_RESULT_W-1:0]  r_result;
    logic                   r_done;
    logic                   r_error;

    logic                   w_finish;
    logic                   w_fin_error;
    logic [c_RESULT_W-1:0]  w_fin_result;

    logic [c_OPERAND_W:0]   w_sum;
    logic [c_OPERAND_W:0]   w_diff;
    logic [c_RESULT_W-1:0]  w_prod;

    logic                   w_div_busy;
    logic                   w_div_done;
    logic                   w_div_dbz;
    logic [c_OPERAND_W-1:0] w_div_quo;
    logic [c_OPERAND_W-1:0] w_div_rem;

    // The divider is loaded on the accepting edge so its first step lands in
    // the first BUSY cycle.
    calc_div_unit u_div (
        .clk           (clk),
        .rst           (rst),
        .i_start       (w_accept && (bus.opcode == OP_DIV)),
        .i_dividend    (bus.operand_A),
        .i_divisor     (bus.operand_B),
        .o_busy        (w_div_busy),
        .o_done        (w_div_done),
        .o_div_by_zero (w_div_dbz),
        .o_quotient    (w_div_quo),
        .o_remainder   (w_div_rem)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_accept     = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_finish) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- operand latch ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= OP_ADD;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= opcode_e'(bus.opcode);
            r_a  <= bus.operand_A;
            r_b  <= bus.operand_B;
        end
    end

`ifdef CALC_GCD_EN
    // Working copies for Euclid; one subtraction per BUSY cycle.
    logic [c_OPERAND_W-1:0] r_ga;
    logic [c_OPERAND_W-1:0] r_gb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ga <= '0;
            r_gb <= '0;
        end else if (w_accept) begin
            r_ga <= bus.operand_A;
            r_gb <= bus.operand_B;
        end else if ((r_state == S_BUSY) && (r_op == OP_GCD) && !w_finish) begin
            if (r_ga > r_gb) begin
                r_ga <= r_ga - r_gb;
            end else begin
                r_gb <= r_gb - r_ga;
            end
        end
    end
`endif

    // ---------------- datapath ----------------
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    // Sign-extended to the product width, the low 8 bits are the signed product.
    assign w_prod = {{4{r_a[3]}}, r_a} * {{4{r_b[3]}}, r_b};

    always_comb begin
        w_finish     = 1'b0;
        w_fin_error  = 1'b0;
        w_fin_result = '0;
        case (r_op)
            OP_ADD: begin
                w_finish     = 1'b1;
                w_fin_result = {3'b000, w_sum};
            end
            OP_SUB: begin
                w_finish     = 1'b1;
                w_fin_result = {3'b000, w_diff};
            end
            OP_MUL: begin
                w_finish     = 1'b1;
                w_fin_result = w_prod;
            end
            OP_AND: begin
                w_finish     = 1'b1;
                w_fin_result = {4'b0000, r_a & r_b};
            end
            OP_OR: begin
                w_finish     = 1'b1;
                w_fin_result = {4'b0000, r_a | r_b};
            end
            OP_XOR: begin
                w_finish     = 1'b1;
                w_fin_result = {4'b0000, r_a ^ r_b};
            end
            OP_DIV: begin
                if (w_div_busy && w_div_dbz) begin
                    w_finish    = 1'b1;
                    w_fin_error = 1'b1;
                end else if (w_div_done) begin
                    w_finish     = 1'b1;
                    w_fin_result = {w_div_quo, w_div_rem};
                end
            end
`ifdef CALC_GCD_EN
            OP_GCD: begin
                if ((r_ga == '0) && (r_gb == '0)) begin
                    w_finish    = 1'b1;
                    w_fin_error = 1'b1;
                end else if (r_ga == '0) begin
                    w_finish     = 1'b1;
                    w_fin_result = {4'b0000, r_gb};
                end else if ((r_gb == '0) || (r_ga == r_gb)) begin
                    w_finish     = 1'b1;
                    w_fin_result = {4'b0000, r_ga};
                end
            end
`endif
            default: begin
                w_finish    = 1'b1;
                w_fin_error = 1'b1;
            end
        endcase
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else if (w_accept) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else if ((r_state == S_BUSY) && w_finish) begin
            r_result <= w_fin_result;
            r_error  <= w_fin_error;
            r_done   <= 1'b1;
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
    assign bus.error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_arithmetic_calculator.sv
`default_nettype none
// ============================================================================
// Module      : tb_arithmetic_calculator
// Description : Self-checking bench for arithmetic_calculator. Expected
//               results are queued when an operation is issued and popped
//               when done rises. Honours CALC_GCD_EN for GCD expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arithmetic_calculator;

    typedef struct {
        logic [7:0] res;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    arithmetic_calculator_if bus ();

    arithmetic_calculator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Independent reference model written from the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t r;
        int ia, ib, sa, sb, x, y, t;
        ia = int'(a);
        ib = int'(b);
        r.res = 8'h00;
        r.err = 1'b0;
        x = 0;
        y = 0;
        t = 0;
        case (op)
            3'd0: r.res = 8'(ia + ib);
            3'd1: r.res = 8'((ia - ib) & 31);
            3'd2: begin
                sa = (ia > 7) ? ia - 16 : ia;
                sb = (ib > 7) ? ib - 16 : ib;
                r.res = 8'(sa * sb);
            end
            3'd3: begin
                if (ib == 0) r.err = 1'b1;
                else         r.res = 8'((ia / ib) * 16 + (ia % ib));
            end
            3'd4: begin
`ifdef CALC_GCD_EN
                if (ia == 0 && ib == 0) begin
                    r.err = 1'b1;
                end else begin
                    x = ia;
                    y = ib;
                    while (y != 0) begin
                        t = x % y;
                        x = y;
                        y = t;
                    end
                    r.res = 8'(x);
                end
`else
                r.err = 1'b1;
`endif
            end
            3'd5: r.res = {4'h0, a & b};
            3'd6: r.res = {4'h0, a | b};
            default: r.res = {4'h0, a ^ b};
        endcase
        return r;
    endfunction

    // Queue the expectation and present one start pulse; returns at #1 after
    // the accepting edge with scrambled inputs (the DUT must have latched).
    task automatic drive_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] er, input logic ee);
        exp_t e;
        e.res = er;
        e.err = ee;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.opcode = op; bus.operand_A = a; bus.operand_B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.opcode    = 3'($urandom);
        bus.operand_A = 4'($urandom);
        bus.operand_B = 4'($urandom);
    endtask

    task automatic wait_done(output logic to, output int cyc);
        to  = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1) begin
            if (cyc >= 40) begin
                to = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.opcode = 3'd0; bus.operand_A = 4'd0; bus.operand_B = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.result !== 8'h00) begin n_bad++; $display("FAIL reset_result: got %h want 00", bus.result); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++;
        if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", bus.error); end
        // Reset and start together: reset wins, nothing starts.
        bus.start = 1'b1; bus.opcode = 3'd0; bus.operand_A = 4'd5; bus.operand_B = 4'd3;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.result !== 8'h00) begin
            n_bad++; $display("FAIL reset_prio: done=%b result=%h want done=0 result=00", bus.done, bus.result);
        end
    endtask

    task automatic test_single_cycle;
        logic [2:0] ops [10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd5, 3'd6, 3'd7};
        logic [3:0] as  [10] = '{4'd5, 4'd15, 4'd8, 4'd3, 4'd3, 4'hD, 4'hD, 4'd12, 4'd12, 4'd12};
        logic [3:0] bs  [10] = '{4'd3, 4'd1, 4'd3, 4'd8, 4'd4, 4'h4, 4'hC, 4'd10, 4'd10, 4'd10};
        logic [7:0] rs  [10] = '{8'h08, 8'h10, 8'h05, 8'h1B, 8'h0C, 8'hF4, 8'h0C, 8'h08, 8'h0E, 8'h06};
        logic to;
        int   cyc;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            drive_op(ops[i], as[i], bs[i], rs[i], 1'b0);
            wait_done(to, cyc);
            e = sb_q.pop_front();
            n_cmp++;
            if (to || bus.result !== e.res || bus.error !== e.err || cyc != 1) begin
                n_bad++;
                $display("FAIL single[%0d] op=%0d: result=%h error=%b cycles=%0d timeout=%b want result=%h error=%b cycles=1",
                         i, ops[i], bus.result, bus.error, cyc, to, e.res, e.err);
            end
        end
    endtask

    task automatic test_div;
        logic [3:0] as [4] = '{4'd10, 4'd10, 4'd10, 4'd15};
        logic [3:0] bs [4] = '{4'd2, 4'd3, 4'd0, 4'd1};
        logic [7:0] rs [4] = '{8'h50, 8'h31, 8'h00, 8'hF0};
        logic       es [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int         cs [4] = '{4, 4, 1, 4};
        logic to;
        int   cyc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_op(3'd3, as[i], bs[i], rs[i], es[i]);
            wait_done(to, cyc);
            e = sb_q.pop_front();
            n_cmp++;
            if (to || bus.result !== e.res || bus.error !== e.err || cyc != cs[i]) begin
                n_bad++;
                $display("FAIL div[%0d]: result=%h error=%b cycles=%0d timeout=%b want result=%h error=%b cycles=%0d",
                         i, bus.result, bus.error, cyc, to, e.res, e.err, cs[i]);
            end
        end
    endtask

    task automatic test_gcd;
`ifdef CALC_GCD_EN
        logic [3:0] as [5] = '{4'd8, 4'd5, 4'd0, 4'd0, 4'd15};
        logic [3:0] bs [5] = '{4'd12, 4'd3, 4'd0, 4'd7, 4'd1};
        logic [7:0] rs [5] = '{8'h04, 8'h01, 8'h00, 8'h07, 8'h01};
        logic       es [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        logic [3:0] as [5] = '{4'd8, 4'd5, 4'd0, 4'd0, 4'd15};
        logic [3:0] bs [5] = '{4'd12, 4'd3, 4'd0, 4'd7, 4'd1};
        logic [7:0] rs [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       es [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        logic to;
        int   cyc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_op(3'd4, as[i], bs[i], rs[i], es[i]);
            wait_done(to, cyc);
            e = sb_q.pop_front();
            n_cmp++;
            if (to || bus.result !== e.res || bus.error !== e.err || cyc > 16) begin
                n_bad++;
                $display("FAIL gcd[%0d]: result=%h error=%b cycles=%0d timeout=%b want result=%h error=%b cycles<=16",
                         i, bus.result, bus.error, cyc, to, e.res, e.err);
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic to;
        int   cyc;
        exp_t e;
        drive_op(3'd3, 4'd10, 4'd3, 8'h31, 1'b0);
        // Request an ADD while the divider is still working.
        bus.start = 1'b1; bus.opcode = 3'd0; bus.operand_A = 4'd1; bus.operand_B = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(to, cyc);
        e = sb_q.pop_front();
        n_cmp++;
        if (to || bus.result !== e.res || bus.error !== e.err) begin
            n_bad++;
            $display("FAIL busy_ignore: result=%h error=%b timeout=%b want result=%h error=%b",
                     bus.result, bus.error, to, e.res, e.err);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.result !== 8'h31) begin
            n_bad++;
            $display("FAIL done_hold: done=%b result=%h want done=1 result=31", bus.done, bus.result);
        end
    endtask

    task automatic test_reset_abort;
        logic seen_done;
        bus.start = 1'b1;
`ifdef CALC_GCD_EN
        bus.opcode = 3'd4;
`else
        bus.opcode = 3'd3;
`endif
        bus.operand_A = 4'd15; bus.operand_B = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen_done !== 1'b0 || bus.result !== 8'h00 || bus.error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort: done_seen=%b result=%h error=%b want done_seen=0 result=00 error=0",
                     seen_done, bus.result, bus.error);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] op;
        logic [3:0] a, b;
        logic to;
        int   cyc;
        exp_t m, e;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom);
            b  = 4'($urandom);
            m  = model(op, a, b);
            drive_op(op, a, b, m.res, m.err);
            wait_done(to, cyc);
            e = sb_q.pop_front();
            n_cmp++;
            if (to || bus.result !== e.res || bus.error !== e.err) begin
                n_bad++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: result=%h error=%b timeout=%b want result=%h error=%b",
                         i, op, a, b, bus.result, bus.error, to, e.res, e.err);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.opcode = 3'd0;
        bus.operand_A = 4'd0;
        bus.operand_B = 4'd0;
        test_reset();
        test_single_cycle();
        test_div();
        test_gcd();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arithmetic_calculator.md
ARITHMETIC_CALCULATOR -- requirements
Module: arithmetic_calculator

Interface
REQ-001 Parameter: none; all widths fixed (4-bit operands, 8-bit result).
REQ-002 clk  input  1  single clock; all logic rising-edge triggered.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  operation request, sampled on rising clk.
REQ-005 opcode  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 GCD, 101 AND, 110 OR, 111 XOR.
REQ-006 operand_A  input  4  first operand.
REQ-007 operand_B  input  4  second operand.
REQ-008 result  output  8  registered result.
REQ-009 done  output  1  result/error valid; level, held until next accepted start.
REQ-010 error  output  1  operation invalid (div by zero, GCD(0,0), undefined opcode).

Function
REQ-011 FSM states IDLE, BUSY, DONE; start is accepted in IDLE or DONE only, and ignored in BUSY.
REQ-012 On accepted start, opcode/operands SHALL be latched; inputs may change afterwards; done and error clear on the next cycle; the FSM enters BUSY.
REQ-013 ADD, SUB, MUL, AND, OR and XOR SHALL complete in one BUSY cycle; done rises on the 2nd rising edge after the start edge.
REQ-014 ADD: result = {3'b0, 5-bit A+B}; result[4] = carry out; unsigned.
REQ-015 SUB: result = {3'b0, 5-bit ({1'b0,A} - {1'b0,B})}; result[3:0] = two's-complement difference; result[4] = 1 on borrow (A<B).
REQ-016 MUL: signed 4x4 -> 8-bit signed product; e.g. -3*4 = 8'hF4, -3*-4 = 8'h0C.
REQ-017 AND/OR/XOR: result = {4'b0, A op B}.
REQ-018 DIV: unsigned restoring division over 4 BUSY cycles; result[7:4] = quotient, result[3:0] = remainder.
REQ-019 DIV with B=0: error=1, result=0, completes after 1 BUSY cycle.
REQ-020 GCD: unsigned subtract-and-swap Euclid, one step per BUSY cycle; result = {4'b0, gcd}; at most 16 BUSY cycles.
REQ-021 GCD with one operand zero: result = the other operand, error=0; GCD(0,0): error=1, result=0.
REQ-022 An undefined opcode (default branch, e.g. GCD compiled out) SHALL give error=1, result=0, after 1 BUSY cycle.
REQ-023 In DONE, result/error/done SHALL hold stable until a new start is accepted or reset.
REQ-024 error=0 for every successful operation.

Reset
REQ-025 rst high at a rising edge: state IDLE, result=0, done=0, error=0, latched operands cleared.
REQ-026 Reset mid-operation SHALL abort it; no done pulse follows.
REQ-027 Reset takes priority over start in the same cycle.

Configuration
REQ-028 Macro CALC_GCD_EN defined: GCD operation implemented per REQ-020/021.
REQ-029 Macro CALC_GCD_EN undefined: GCD logic absent; opcode 100 is treated as undefined per REQ-022.

Structure
REQ-030 Package calc_pkg SHALL hold the opcode enum, the FSM state enum, and width constants (operand 4, result 8).
REQ-031 Sub-module calc_div_unit SHALL implement the iterative 4-bit restoring divider (start, busy/done, quotient, remainder, div-by-zero flag).
REQ-032 The top module contains the FSM, single-cycle ops, GCD datapath, and output registers.

Verification
REQ-033 ADD 5+3 -> result=8'h08, error=0; ADD 15+1 -> result=8'h10 (carry=1).
REQ-034 SUB 8-3 -> 8'h05; SUB 3-8 -> result[3:0]=4'hB, result[4]=1, error=0.
REQ-035 MUL 3*4 -> 8'h0C; 4'hD*4'h4 -> 8'hF4; 4'hD*4'hC -> 8'h0C.
REQ-036 DIV 10/2 -> 8'h50; 10/3 -> 8'h31; 10/0 -> error=1, result=0.
REQ-037 GCD(8,12) -> 8'h04; GCD(5,3) -> 8'h01; GCD(0,0) -> error=1 (with CALC_GCD_EN).
REQ-038 AND/OR/XOR of 12,10 -> 8'h08/8'h0E/8'h06; start during BUSY ignored; rst during GCD aborts with done=0.
